// File: rtl/clock_divider_prog.sv
// Programmable clock divider: divides clock_in by a runtime-loadable N (>= 2).
// A new divisor is held pending and applied only at an enabled period wrap.
module clock_divider_prog #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_value,
  output logic             clock_out,
  output logic             tick,
  output logic             div_ack,
  output logic             div_err
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] half_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;

  always_comb begin
    count_d = count_q;
    n_d     = n_q;
    p_d     = p_q;
    pend_d  = pend_q;
    tick_d  = 1'b0;
    ack_d   = 1'b0;
    err_d   = 1'b0;

    if (enable) begin
      if (count_q == n_q - ONE) begin
        count_d = '0;
        tick_d  = 1'b1;
        if (pend_q) begin
          n_d    = p_q;
          pend_d = 1'b0;
          ack_d  = 1'b1;
        end
      end else begin
        count_d = count_q + ONE;
      end
    end

    // Evaluated after the wrap so a load coinciding with a wrap stays pending.
    if (div_load) begin
      if (div_value < TWO) begin
        err_d = 1'b1;
      end else begin
        p_d    = div_value;
        pend_d = 1'b1;
      end
    end

    // Duty threshold uses the divisor in force next cycle, so a switch is clean.
    half_d = n_d - (n_d >> 1);
    clk_d  = (count_d < half_d);
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= DEF_DIV - ONE;
      n_q     <= DEF_DIV;
      p_q     <= DEF_DIV;
      pend_q  <= 1'b0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      n_q     <= n_d;
      p_q     <= p_d;
      pend_q  <= pend_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign clock_out = clk_q;
  assign tick      = tick_q;
  assign div_ack   = ack_q;
  assign div_err   = err_q;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Bench for clock_divider_prog: directed scenarios plus random traffic,
// scored against a phase/period model of the divider.
module tb_clock_divider_prog;

  localparam int unsigned W   = 6;
  localparam int unsigned DEF = 4;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         ld;
  logic [W-1:0] val;
  logic         clk_o, tick_o, ack_o, err_o;

  int total = 0;
  int bad   = 0;

  // Reference model: position within the current output period and divisor.
  int m_n, m_p, m_phase;
  bit m_pend;
  bit e_tick, e_ack, e_err;

  clock_divider_prog #(.WIDTH(W), .DEFAULT_DIV(DEF)) dut (
    .clock_in (clk),
    .reset_n  (rst_n),
    .enable   (en),
    .div_load (ld),
    .div_value(val),
    .clock_out(clk_o),
    .tick     (tick_o),
    .div_ack  (ack_o),
    .div_err  (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%b expected=%b (N=%0d phase=%0d)",
               tag, $time, got, exp, m_n, m_phase);
    end
  endtask

  function automatic bit exp_clk();
    return m_phase < (m_n + 1) / 2;
  endfunction

  task automatic model_reset();
    m_n = DEF; m_p = DEF; m_pend = 0; m_phase = DEF - 1;
    e_tick = 0; e_ack = 0; e_err = 0;
  endtask

  task automatic model_step(input bit e, input bit l, input int v);
    e_tick = 0; e_ack = 0;
    e_err  = l && (v < 2);
    if (e) begin
      if (m_phase == m_n - 1) begin
        m_phase = 0;
        e_tick  = 1;
        if (m_pend) begin
          m_n = m_p; m_pend = 0; e_ack = 1;
        end
      end else begin
        m_phase++;
      end
    end
    if (l && v >= 2) begin
      m_p = v; m_pend = 1;
    end
  endtask

  task automatic check_all(input string ctx);
    check_eq({ctx, ".clock_out"}, clk_o,  exp_clk());
    check_eq({ctx, ".tick"},      tick_o, e_tick);
    check_eq({ctx, ".div_ack"},   ack_o,  e_ack);
    check_eq({ctx, ".div_err"},   err_o,  e_err);
  endtask

  task automatic cycle(input bit e, input bit l, input int v);
    en = e; ld = l; val = W'(v);
    @(posedge clk);
    model_step(e, l, v);
    #1;
    check_all("cyc");
    ld = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 0);
  endtask

  // Asynchronous reset pulse taken between edges; outputs must drop at once.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    @(posedge clk);
    #1;
    check_all("rst_held");
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; ld = 1'b0; val = '0;
    model_reset();
    #3;
    check_all("rst_init");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Default N=4 pattern, tick on first edge.
    run(9);
    // Load 5 mid-period.
    cycle(1'b1, 1'b1, 5);
    run(14);
    // Rejected divisors.
    cycle(1'b1, 1'b1, 1);
    run(3);
    cycle(1'b1, 1'b1, 0);
    run(8);
    // Two loads before one wrap, last wins.
    cycle(1'b1, 1'b1, 7);
    cycle(1'b1, 1'b1, 3);
    run(12);
    // Load coincident with a wrap waits for the following wrap.
    for (int i = 0; i < 8 && m_phase != m_n - 2; i++) cycle(1'b1, 1'b0, 0);
    cycle(1'b1, 1'b0, 0);
    cycle(1'b1, 1'b1, 4);
    run(10);
    // Frozen with a load captured, then resume.
    cycle(1'b1, 1'b0, 0);
    cycle(1'b0, 1'b1, 6);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 0);
    run(16);
    // Reset with a load pending.
    cycle(1'b1, 1'b1, 9);
    do_reset();
    run(10);
    // Boundary divisors.
    cycle(1'b1, 1'b1, 2);
    run(10);
    cycle(1'b1, 1'b1, (1 << W) - 1);
    run(140);
    cycle(1'b1, 1'b1, DEF);
    run(70);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit e, l;
      int v;
      e = ($urandom_range(0, 7) != 0);
      l = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 5))
        0:       v = $urandom_range(0, 1);
        1:       v = $urandom_range(2, (1 << W) - 1);
        default: v = $urandom_range(2, 9);
      endcase
      if ($urandom_range(0, 399) == 0) do_reset();
      else cycle(e, l, v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
